// File: rtl/conv_bus_arbiter.sv
// Parametrised SRAM bus switch for NUM_UNITS compute units with a drain/wake mode-change FSM.
// Optional latch-based per-unit clock gating when CONV_BUS_CG_EN is defined.
module conv_bus_arbiter #(
  parameter int NUM_UNITS   = 3,
  parameter int NUM_BUSES   = 5,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int WREQ_W      = 4,
  parameter logic [WREQ_W-1:0] WREQ_IDLE = '1,
  parameter int DRAIN_MAX   = 64,
  parameter int WAKE_CYCLES = 1,
  parameter int MODE_W      = $clog2(NUM_UNITS+1)
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [MODE_W-1:0]                                  mode_i,
  input  logic                                               mode_valid_i,
  output logic                                               mode_ready_o,
  output logic [MODE_W-1:0]                                  cur_mode_o,
  output logic                                               busy_o,
  output logic                                               drain_timeout_o,
  output logic [NUM_UNITS-1:0]                               unit_clk_en_o,
  output logic [NUM_UNITS-1:0]                               gated_clk_o,
  input  logic [NUM_UNITS-1:0][NUM_BUSES-1:0]                u_cs_i,
  input  logic [NUM_UNITS-1:0][NUM_BUSES-1:0]                u_oe_i,
  input  logic [NUM_UNITS-1:0][NUM_BUSES-1:0][ADDR_W-1:0]    u_addr_i,
  input  logic [NUM_UNITS-1:0][NUM_BUSES-1:0][WREQ_W-1:0]    u_wreq_i,
  input  logic [NUM_UNITS-1:0][NUM_BUSES-1:0][DATA_W-1:0]    u_wdata_i,
  output logic [NUM_UNITS-1:0][NUM_BUSES-1:0][DATA_W-1:0]    u_rdata_o,
  output logic [NUM_BUSES-1:0]                               m_cs_o,
  output logic [NUM_BUSES-1:0]                               m_oe_o,
  output logic [NUM_BUSES-1:0][ADDR_W-1:0]                   m_addr_o,
  output logic [NUM_BUSES-1:0][WREQ_W-1:0]                   m_wreq_o,
  output logic [NUM_BUSES-1:0][DATA_W-1:0]                   m_wdata_o,
  input  logic [NUM_BUSES-1:0][DATA_W-1:0]                   m_rdata_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_WAKE   = 2'd3;

  localparam int DCNT_W = $clog2(DRAIN_MAX+1);
  localparam int WCNT_W = $clog2(WAKE_CYCLES+1);
  localparam logic [MODE_W:0]     MAX_MODE   = (MODE_W+1)'(NUM_UNITS);
  localparam logic [DCNT_W-1:0]   DRAIN_LAST = DCNT_W'(DRAIN_MAX-1);
  localparam logic [WCNT_W-1:0]   WAKE_LAST  = WCNT_W'(WAKE_CYCLES-1);

  logic [1:0]                          state;
  logic [MODE_W-1:0]                   tgt_mode;
  logic [DCNT_W-1:0]                   drain_cnt;
  logic [WCNT_W-1:0]                   wake_cnt;
  logic [NUM_BUSES-1:0]                rd_pending;
  logic [NUM_BUSES-1:0][MODE_W-1:0]    rd_owner;

  logic [MODE_W-1:0] req_mode;
  logic [MODE_W-1:0] owner_idx;
  logic              granted;
  logic              quiet;

  function automatic logic [NUM_UNITS-1:0] mode_onehot(input logic [MODE_W-1:0] m);
    mode_onehot = '0;
    for (int unsigned u = 0; u < NUM_UNITS; u++)
      if (m == MODE_W'(u + 1)) mode_onehot[u] = 1'b1;
  endfunction

  assign req_mode     = ({1'b0, mode_i} > MAX_MODE) ? '0 : mode_i;
  assign mode_ready_o = mode_valid_i & ~rst & ((state == S_IDLE) | (state == S_ACTIVE));
  assign busy_o       = (state == S_DRAIN) | (state == S_WAKE);
  assign granted      = (state == S_ACTIVE) | (state == S_DRAIN);
  assign owner_idx    = cur_mode_o - MODE_W'(1);
  // m_cs_o already carries only the owner's chip selects while granted
  assign quiet        = ~(|m_cs_o) & ~(|rd_pending);

  always_comb begin
    m_cs_o    = '0;
    m_oe_o    = '0;
    m_addr_o  = '0;
    m_wreq_o  = {NUM_BUSES{WREQ_IDLE}};
    m_wdata_o = '0;
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      if (granted && owner_idx == MODE_W'(u)) begin
        m_cs_o    = u_cs_i[u];
        m_oe_o    = u_oe_i[u];
        m_addr_o  = u_addr_i[u];
        m_wreq_o  = u_wreq_i[u];
        m_wdata_o = u_wdata_i[u];
      end
    end
  end

  always_comb begin
    u_rdata_o = '0;
    for (int unsigned u = 0; u < NUM_UNITS; u++)
      for (int unsigned b = 0; b < NUM_BUSES; b++)
        if (rd_pending[b] && rd_owner[b] == MODE_W'(u)) u_rdata_o[u][b] = m_rdata_i[b];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      tgt_mode        <= '0;
      cur_mode_o      <= '0;
      unit_clk_en_o   <= '0;
      drain_timeout_o <= 1'b0;
      drain_cnt       <= '0;
      wake_cnt        <= '0;
      rd_pending      <= '0;
      rd_owner        <= '0;
    end else begin
      drain_timeout_o <= 1'b0;
      rd_pending      <= m_cs_o & m_oe_o;
      rd_owner        <= {NUM_BUSES{owner_idx}};
      case (state)
        S_IDLE: begin
          if (mode_valid_i && req_mode != '0) begin
            tgt_mode      <= req_mode;
            wake_cnt      <= '0;
            unit_clk_en_o <= mode_onehot(req_mode);
            state         <= S_WAKE;
          end
        end
        S_ACTIVE: begin
          if (mode_valid_i && req_mode != cur_mode_o) begin
            tgt_mode  <= req_mode;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (quiet || drain_cnt == DRAIN_LAST) begin
            drain_timeout_o <= ~quiet;
            cur_mode_o      <= '0;
            wake_cnt        <= '0;
            unit_clk_en_o   <= mode_onehot(tgt_mode);
            state           <= (tgt_mode != '0) ? S_WAKE : S_IDLE;
          end else begin
            drain_cnt <= drain_cnt + DCNT_W'(1);
          end
        end
        default: begin
          if (wake_cnt == WAKE_LAST) begin
            cur_mode_o <= tgt_mode;
            state      <= S_ACTIVE;
          end else begin
            wake_cnt <= wake_cnt + WCNT_W'(1);
          end
        end
      endcase
    end
  end

`ifdef CONV_BUS_CG_EN
  logic [NUM_UNITS-1:0] cg_en_lat;
  always_latch begin
    if (!clk) cg_en_lat <= unit_clk_en_o;
  end
  assign gated_clk_o = {NUM_UNITS{clk}} & cg_en_lat;
`else
  assign gated_clk_o = {NUM_UNITS{clk}};
`endif

endmodule
